rr_grant_fsm: RTL and testbench

RR_GRANT_FSM -- requirements
Module: rr_grant_fsm

---
 rtl/rr_grant_fsm.sv | 130 +++++++++++++
 tb/tb_rr_grant_fsm.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/rr_grant_fsm.sv
// rtl/rr_grant_fsm.sv - four-port round-robin grant FSM with hold timeout
// Registered IDLE/GRANT/RELEASE arbiter; rotation is driven externally via change_order_o.
module rr_grant_fsm #(
    parameter int NUM_PORTS = 4,
    parameter int MAX_HOLD  = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_PORTS-1:0] req_i,
    input  logic                 release_i,
    input  logic [NUM_PORTS-1:0] priority_order_i,
    output logic [NUM_PORTS-1:0] grant_o,
    output logic                 busy_o,
    output logic                 change_order_o,
    output logic                 timeout_o
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);
    localparam logic [7:0] HOLD_SAT  = 8'(MAX_HOLD);

    state_t               r_state, w_state_nxt;
    logic [NUM_PORTS-1:0] r_grant, w_grant_nxt;
    logic [7:0]           r_hold, w_hold_nxt;
    logic                 r_busy, w_busy_nxt;
    logic                 r_change, w_change_nxt;
    logic                 r_timeout, w_timeout_nxt;

    logic [1:0]           w_prio_idx;
    logic [1:0]           w_win_idx;
    logic                 w_granted_req;
    logic                 w_hold_hit;

    // Malformed priority vectors collapse to the lowest set bit, or port 0 if empty.
    always_comb begin
        w_prio_idx = 2'd0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (priority_order_i[k]) begin
                w_prio_idx = 2'(k);
            end
        end
    end

    always_comb begin
        logic       v_found;
        logic [1:0] v_idx;
        v_found   = 1'b0;
        v_idx     = 2'd0;
        w_win_idx = 2'd0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            v_idx = w_prio_idx + 2'(k);
            if (!v_found && req_i[v_idx]) begin
                v_found   = 1'b1;
                w_win_idx = v_idx;
            end
        end
    end

    assign w_granted_req = |(req_i & r_grant);
    assign w_hold_hit    = (r_hold == HOLD_LAST);

    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_hold_nxt    = r_hold;
        w_busy_nxt    = 1'b0;
        w_change_nxt  = 1'b0;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_grant_nxt = '0;
                if (|req_i) begin
                    w_state_nxt = ST_GRANT;
                    w_grant_nxt = NUM_PORTS'(1) << w_win_idx;
                    w_hold_nxt  = 8'd0;
                    w_busy_nxt  = 1'b1;
                end
            end
            ST_GRANT: begin
                w_busy_nxt = 1'b1;
                if (release_i || !w_granted_req || w_hold_hit) begin
                    w_state_nxt   = ST_RELEASE;
                    w_grant_nxt   = '0;
                    w_change_nxt  = 1'b1;
                    // Timeout only when the counter alone forced the release.
                    w_timeout_nxt = w_hold_hit && !release_i && w_granted_req;
                end else if (r_hold != HOLD_SAT) begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end
            ST_RELEASE: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= ST_IDLE;
            r_grant   <= '0;
            r_hold    <= 8'd0;
            r_busy    <= 1'b0;
            r_change  <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_hold    <= w_hold_nxt;
            r_busy    <= w_busy_nxt;
            r_change  <= w_change_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign grant_o        = r_grant;
    assign busy_o         = r_busy;
    assign change_order_o = r_change;
    assign timeout_o      = r_timeout;

endmodule

// File: tb/tb_rr_grant_fsm.sv
// tb/tb_rr_grant_fsm.sv - self-checking bench for rr_grant_fsm
module tb_rr_grant_fsm;

    localparam int MAX_HOLD = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] req_i = 4'b0;
    logic       release_i = 1'b0;
    logic [3:0] prio_drv = 4'b0001;
    logic [3:0] cl_prio = 4'b0001;
    logic       closed_loop = 1'b0;
    logic [3:0] priority_order_i;
    logic [3:0] grant_o;
    logic       busy_o, change_order_o, timeout_o;

    int checks = 0;
    int errors = 0;

    assign priority_order_i = closed_loop ? cl_prio : prio_drv;

    rr_grant_fsm #(.NUM_PORTS(4), .MAX_HOLD(MAX_HOLD)) dut (
        .clk              (clk),
        .reset            (reset),
        .req_i            (req_i),
        .release_i        (release_i),
        .priority_order_i (priority_order_i),
        .grant_o          (grant_o),
        .busy_o           (busy_o),
        .change_order_o   (change_order_o),
        .timeout_o        (timeout_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 waiting, 1 holding a grant, 2 handing back.
    int   m_phase = 0;
    int   m_port  = 0;
    int   m_held  = 0;
    logic [3:0] e_grant = 4'b0;
    logic e_busy = 1'b0, e_change = 1'b0, e_timeout = 1'b0;

    function automatic int pick_winner(input logic [3:0] req, input logic [3:0] prio);
        int p = 0;
        for (int k = 3; k >= 0; k--) if (prio[k]) p = k;
        for (int k = 0; k < 4; k++) if (req[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_phase = 0; m_held = 0;
            e_grant = 4'b0; e_busy = 0; e_change = 0; e_timeout = 0;
        end else begin
            e_change = 0; e_timeout = 0;
            if (m_phase == 0) begin
                if (req_i != 4'b0) begin
                    m_port  = pick_winner(req_i, priority_order_i);
                    m_held  = 0;
                    m_phase = 1;
                    e_grant = 4'b0001 << m_port;
                    e_busy  = 1;
                end else begin
                    e_grant = 4'b0; e_busy = 0;
                end
            end else if (m_phase == 1) begin
                if (release_i || !req_i[m_port] || m_held == MAX_HOLD - 1) begin
                    e_timeout = (m_held == MAX_HOLD - 1) && !release_i && req_i[m_port];
                    e_change  = 1;
                    e_grant   = 4'b0;
                    m_phase   = 2;
                end else if (m_held < MAX_HOLD) begin
                    m_held++;
                end
            end else begin
                m_phase = 0; e_grant = 4'b0; e_busy = 0;
            end
        end
    end

    always @(negedge clk) begin
        check("cyc_grant",   int'(grant_o),        int'(e_grant));
        check("cyc_busy",    int'(busy_o),         int'(e_busy));
        check("cyc_change",  int'(change_order_o), int'(e_change));
        check("cyc_timeout", int'(timeout_o),      int'(e_timeout));
        if (closed_loop && change_order_o) cl_prio = {cl_prio[2:0], cl_prio[3]};
    end

    initial begin
        int tmo_seen;
        int seq[$];
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_grant", int'(grant_o), 0);
        check("rst_busy", int'(busy_o), 0);
        check("rst_change", int'(change_order_o), 0);

        reset = 1'b1; prio_drv = 4'b0001; req_i = 4'b0110;
        @(negedge clk);
        check("pri0_grant", int'(grant_o), 4'b0010);
        check("pri0_busy", int'(busy_o), 1);
        req_i = 4'b0;
        repeat (2) @(negedge clk);

        prio_drv = 4'b1000; req_i = 4'b0011;
        @(negedge clk);
        check("wrap_grant", int'(grant_o), 4'b0001);
        req_i = 4'b0;
        repeat (2) @(negedge clk);

        prio_drv = 4'b0100; req_i = 4'b0100;
        @(negedge clk);
        check("rel_grant", int'(grant_o), 4'b0100);
        release_i = 1'b1;
        @(negedge clk);
        release_i = 1'b0; req_i = 4'b0;
        check("rel_grant0", int'(grant_o), 0);
        check("rel_change", int'(change_order_o), 1);
        check("rel_timeout", int'(timeout_o), 0);
        @(negedge clk);
        check("rel_idle_change", int'(change_order_o), 0);
        check("rel_idle_busy", int'(busy_o), 0);

        prio_drv = 4'b0001; req_i = 4'b0001;
        for (int i = 0; i < MAX_HOLD; i++) begin
            @(negedge clk);
            check("hold_grant", int'(grant_o), 4'b0001);
            check("hold_no_tmo", int'(timeout_o), 0);
            prio_drv = 4'b0010;
            req_i = 4'b1111;
        end
        @(negedge clk);
        check("hold_change", int'(change_order_o), 1);
        check("hold_timeout", int'(timeout_o), 1);
        check("hold_grant0", int'(grant_o), 0);
        req_i = 4'b0;
        @(negedge clk);

        prio_drv = 4'b0100; req_i = 4'b0100;
        @(negedge clk);
        check("mid_grant", int'(grant_o), 4'b0100);
        #2 reset = 1'b0;
        #1 check("mid_rst_grant", int'(grant_o), 0);
        check("mid_rst_busy", int'(busy_o), 0);
        @(negedge clk);
        check("mid_rst_change", int'(change_order_o), 0);
        reset = 1'b1;
        @(negedge clk);
        check("mid_regrant", int'(grant_o), 4'b0100);
        req_i = 4'b0;
        repeat (2) @(negedge clk);

        cl_prio = 4'b0001; closed_loop = 1'b1; req_i = 4'b1111; release_i = 1'b1;
        for (int c = 0; c < 40 && seq.size() < 8; c++) begin
            @(negedge clk);
            if (grant_o != 4'b0) begin
                for (int k = 0; k < 4; k++) if (grant_o[k]) seq.push_back(k);
            end
        end
        check("loop_count", seq.size(), 8);
        for (int i = 0; i < seq.size(); i++) check("loop_order", seq[i], i % 4);
        closed_loop = 1'b0; req_i = 4'b0; release_i = 1'b0;
        repeat (3) @(negedge clk);

        tmo_seen = 0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            if (timeout_o) tmo_seen++;
            if ($urandom_range(3) == 0) req_i = 4'($urandom);
            prio_drv = ($urandom_range(7) == 0) ? 4'($urandom) : (4'b0001 << $urandom_range(3));
            release_i = ($urandom_range(5) == 0);
        end
        checks++;
        if (tmo_seen == 0) begin
            errors++;
            $display("FAIL rand_timeouts: got %0d expected nonzero", tmo_seen);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
